// File: rtl/io_pad_responder_pkg.sv
// Shared command codes, response size and responder FSM states for the 1-wire pad link.
package io_pad_pkg;

  localparam logic [31:0] CMD_POLL      = 32'h4A10000C;
  localparam logic [31:0] CMD_HEARTBEAT = 32'h4AFE0000;
  localparam int unsigned RESP_WORDS    = 12;

  typedef enum logic [3:0] {
    RS_IDLE,
    RS_RX_BIT,
    RS_RX_WAITEDGE,
    RS_DECODE,
    RS_SNAP,
    RS_TURN,
    RS_TX_PRE,
    RS_TX_BIT,
    RS_TX_GAP
  } rs_state_e;

endpackage

// File: rtl/io_pad_responder_synch_3.sv
// Three-flop synchroniser for the asynchronous pad line; resets to the idle-high level.
module synch_3 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) sync_q <= {3{RESET_VAL}};
    else       sync_q <= sync_d;
  end

  assign q = sync_q[2];

endmodule

// File: rtl/io_pad_responder.sv
// Pad-side responder of the 1-wire pad link: receives commands, answers polls with 12 words.
// IO_PAD_RESPONDER_SNAPSHOT_EN captures all words at decode so a response is coherent.
module io_pad_responder
  import io_pad_pkg::*;
#(
  parameter int unsigned BITLEN     = 60,
  parameter int unsigned TURNAROUND = 512,
  parameter int unsigned WORD_GAP   = 32,
  parameter int unsigned RX_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pad_in,
  output logic        pad_out,
  output logic        pad_oe,
  output logic [3:0]  rd_idx,
  input  logic [31:0] rd_data,
  output logic        busy,
  output logic        poll_seen,
  output logic        hb_seen,
  output logic        cmd_err,
  output logic        rx_abort
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] C_SAMPLE    = CW'(BITLEN / 2 - 4);
  localparam logic [CW-1:0] C_BIT_END   = CW'(BITLEN * 5 / 6);
  localparam logic [CW-1:0] C_THIRD     = CW'(BITLEN / 3);
  localparam logic [CW-1:0] C_TWO_THIRD = CW'(2 * BITLEN / 3);
  localparam logic [CW-1:0] C_CELL_LAST = CW'(BITLEN - 1);
  localparam logic [CW-1:0] C_TURN_LAST = CW'(TURNAROUND - 1);
  localparam logic [CW-1:0] C_GAP_LAST  = CW'(WORD_GAP - 1);
  localparam logic [CW-1:0] C_RX_TO     = CW'(RX_TIMEOUT);
  localparam logic [CW-1:0] C_PRE_LAST  = CW'(3);
  localparam logic [3:0]    LAST_IDX    = 4'(RESP_WORDS - 1);

  rs_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   rx_sr_q, rx_sr_d;
  logic [31:0]   tx_sr_q, tx_sr_d;
  logic [3:0]    rd_idx_q, rd_idx_d;
  logic          pad_prev_q, pad_prev_d;
  logic          pad_s;
  logic          edge_ok;
  logic [31:0]   tx_src;

  synch_3 #(.RESET_VAL(1'b1)) u_pad_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pad_in),
    .q     (pad_s)
  );

`ifdef IO_PAD_RESPONDER_SNAPSHOT_EN
  logic        snap_we;
  logic [31:0] snap_q [RESP_WORDS];

  always_ff @(posedge clk) begin
    if (snap_we) snap_q[rd_idx_q] <= rd_data;
  end

  assign tx_src = snap_q[rd_idx_q];
`else
  assign tx_src = rd_data;
`endif

  // Line drive is decoded from registered state so reset releases the pad on the next clock.
  always_comb begin
    pad_oe  = (state_q == RS_TX_PRE) || (state_q == RS_TX_BIT);
    pad_out = 1'b1;
    if (state_q == RS_TX_BIT) begin
      if (cnt_q < C_THIRD)          pad_out = 1'b0;
      else if (cnt_q < C_TWO_THIRD) pad_out = tx_sr_q[31];
    end
  end

  assign edge_ok = pad_prev_q && !pad_s && !pad_oe &&
                   (state_q != RS_TURN) && (state_q != RS_TX_GAP);
  assign busy    = (state_q != RS_IDLE);
  assign rd_idx  = rd_idx_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    rd_idx_d   = rd_idx_q;
    pad_prev_d = pad_s;
    poll_seen  = 1'b0;
    hb_seen    = 1'b0;
    cmd_err    = 1'b0;
    rx_abort   = 1'b0;
`ifdef IO_PAD_RESPONDER_SNAPSHOT_EN
    snap_we    = 1'b0;
`endif
    case (state_q)
      RS_IDLE: begin
        cnt_d = '0;
        if (edge_ok) state_d = RS_RX_BIT;
      end
      RS_RX_BIT: begin
        if (cnt_q == C_SAMPLE) rx_sr_d = {rx_sr_q[30:0], pad_s};
        if (cnt_q == C_BIT_END) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          cnt_d     = '0;
          state_d   = (bit_cnt_q == 5'd31) ? RS_DECODE : RS_RX_WAITEDGE;
        end
      end
      RS_RX_WAITEDGE: begin
        if (edge_ok) begin
          cnt_d   = '0;
          state_d = RS_RX_BIT;
        end else if (cnt_q == C_RX_TO) begin
          rx_abort  = 1'b1;
          bit_cnt_d = '0;
          state_d   = RS_IDLE;
        end
      end
      RS_DECODE: begin
        bit_cnt_d = '0;
        cnt_d     = '0;
        if (rx_sr_q == CMD_POLL) begin
          poll_seen = 1'b1;
          rd_idx_d  = '0;
`ifdef IO_PAD_RESPONDER_SNAPSHOT_EN
          state_d   = RS_SNAP;
`else
          state_d   = RS_TURN;
`endif
        end else if (rx_sr_q == CMD_HEARTBEAT) begin
          hb_seen = 1'b1;
          state_d = RS_IDLE;
        end else begin
          cmd_err = 1'b1;
          state_d = RS_IDLE;
        end
      end
`ifdef IO_PAD_RESPONDER_SNAPSHOT_EN
      RS_SNAP: begin
        snap_we = 1'b1;
        cnt_d   = '0;
        if (rd_idx_q == LAST_IDX) begin
          rd_idx_d = '0;
          state_d  = RS_TURN;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
`endif
      RS_TURN: begin
        if (cnt_q == C_TURN_LAST) begin
          cnt_d   = '0;
          state_d = RS_TX_PRE;
        end
      end
      RS_TX_PRE: begin
        if (cnt_q == C_PRE_LAST) begin
          tx_sr_d = tx_src;
          cnt_d   = '0;
          state_d = RS_TX_BIT;
        end
      end
      RS_TX_BIT: begin
        if (cnt_q == C_CELL_LAST) begin
          tx_sr_d   = {tx_sr_q[30:0], 1'b0};
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'd31) state_d = RS_TX_GAP;
        end
      end
      RS_TX_GAP: begin
        if (cnt_q == C_GAP_LAST) begin
          cnt_d = '0;
          if (rd_idx_q == LAST_IDX) begin
            state_d = RS_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
            state_d  = RS_TX_PRE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RS_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      rd_idx_q   <= '0;
      pad_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      rd_idx_q   <= rd_idx_d;
      pad_prev_q <= pad_prev_d;
    end
  end

endmodule

// File: tb/tb_io_pad_responder.sv
// Bench for io_pad_responder: a host model drives command cells, a line decoder recovers responses.
module tb_io_pad_responder;
  import io_pad_pkg::*;

  localparam int unsigned BITLEN     = 30;
  localparam int unsigned TURNAROUND = 100;
  localparam int unsigned WORD_GAP   = 32;
  localparam int unsigned RX_TIMEOUT = 255;
`ifdef IO_PAD_RESPONDER_SNAPSHOT_EN
  localparam int unsigned SNAP_CYC = RESP_WORDS;
`else
  localparam int unsigned SNAP_CYC = 0;
`endif
  localparam int unsigned FALL_LIMIT = TURNAROUND + SNAP_CYC + 4 * BITLEN + WORD_GAP + 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_drive = 1'b1;
  logic        pad_in, pad_out, pad_oe, busy;
  logic        poll_seen, hb_seen, cmd_err, rx_abort;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;
  logic        line;

  // Open-drain style line: either side pulls low, otherwise the external pull-up wins.
  assign line   = (pad_oe ? pad_out : 1'b1) & host_drive;
  assign pad_in = line;

  always #5 clk = ~clk;

  io_pad_responder #(
    .BITLEN     (BITLEN),
    .TURNAROUND (TURNAROUND),
    .WORD_GAP   (WORD_GAP),
    .RX_TIMEOUT (RX_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pad_in    (pad_in),
    .pad_out   (pad_out),
    .pad_oe    (pad_oe),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .busy      (busy),
    .poll_seen (poll_seen),
    .hb_seen   (hb_seen),
    .cmd_err   (cmd_err),
    .rx_abort  (rx_abort)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  longint      cyc = 0;
  int          n_poll = 0, n_hb = 0, n_err = 0, n_abort = 0, n_oe = 0;
  longint      poll_cyc = 0, abort_cyc = 0;
  logic        busy_after_hb = 1'b1;
  bit          hb_pend = 1'b0;
  logic [31:0] src_base = 32'h1000_0000;
  logic [31:0] src_step = 32'h1;
  bit          src_mask = 1'b0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] model_word(logic [31:0] base, logic [31:0] step, bit mask,
                                             int unsigned idx);
    logic [31:0] w;
    w = base + idx * step;
    if (mask && (idx % 3 == 2)) w = w & 32'h0000_FFFF;
    return w;
  endfunction

  always_comb rd_data = model_word(src_base, src_step, src_mask, 32'(rd_idx));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (poll_seen) begin n_poll++; poll_cyc = cyc; end
    if (cmd_err) n_err++;
    if (rx_abort) begin n_abort++; abort_cyc = cyc; end
    if (pad_oe) n_oe++;
    if (hb_seen) begin
      n_hb++;
      hb_pend = 1'b1;
    end else if (hb_pend) begin
      busy_after_hb = busy;
      hb_pend = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits, output longint last_start);
    last_start = cyc;
    for (int i = 31; i >= 32 - nbits; i--) begin
      last_start = cyc;
      host_drive = 1'b0;
      repeat (BITLEN / 3) @(negedge clk);
      host_drive = w[i];
      repeat (BITLEN / 3) @(negedge clk);
      host_drive = 1'b1;
      repeat (BITLEN / 3) @(negedge clk);
    end
  endtask

  task automatic get_word(output logic [31:0] w, output bit to, output longint first_fall);
    w = '0;
    to = 1'b0;
    first_fall = 0;
    for (int b = 0; b < 32; b++) begin
      int   n;
      logic prev;
      n = 0;
      prev = line;
      forever begin
        @(negedge clk);
        if (prev && !line) break;
        prev = line;
        n++;
        if (n > int'(FALL_LIMIT)) begin
          to = 1'b1;
          return;
        end
      end
      if (b == 0) first_fall = cyc;
      repeat (BITLEN / 2) @(negedge clk);
      w = {w[30:0], line};
    end
  endtask

  task automatic collect(input string tag, input int nwords, input bit check_lat);
    logic [31:0] w;
    bit          to;
    longint      ff;
    to = 1'b0;
    for (int k = 0; k < nwords; k++) begin
      get_word(w, to, ff);
      if (to) break;
      if (check_lat && k == 0)
        check_eq({tag, "_latency"}, 32'(ff - poll_cyc), 32'(TURNAROUND + 5 + SNAP_CYC));
      check_eq($sformatf("%s_word%0d", tag, k), w, exp_q.pop_front());
    end
    check_eq({tag, "_timeout"}, 32'(to), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < int'(2 * BITLEN + WORD_GAP + 50)) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_oe_end"}, 32'(pad_oe), 32'd0);
  endtask

  task automatic expect_poll(input logic [31:0] base, input logic [31:0] step, input bit mask);
    src_base = base;
    src_step = step;
    src_mask = mask;
    for (int unsigned i = 0; i < RESP_WORDS; i++) exp_q.push_back(model_word(base, step, mask, i));
  endtask

  initial begin
    longint      ls, lat;
    int          p0, h0, e0, a0, o0, n;
    logic [31:0] cmd, base_a, base_b;

    repeat (4) @(negedge clk);
    check_eq("rst_pad_oe", 32'(pad_oe), 32'd0);
    check_eq("rst_pad_out", 32'(pad_out), 32'd1);
    check_eq("rst_rd_idx", 32'(rd_idx), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pulses", 32'({poll_seen, hb_seen, cmd_err, rx_abort}), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Directed poll with the plain incrementing source.
    p0 = n_poll;
    expect_poll(32'h1000_0000, 32'h1, 1'b0);
    send_word(CMD_POLL, 32, ls);
    collect("poll1", 12, 1'b1);
    check_eq("poll1_pulses", 32'(n_poll - p0), 32'd1);
    wait_idle("poll1");

    h0 = n_hb; o0 = n_oe;
    send_word(CMD_HEARTBEAT, 32, ls);
    repeat (10) @(negedge clk);
    check_eq("hb_pulses", 32'(n_hb - h0), 32'd1);
    check_eq("hb_busy_next", 32'(busy_after_hb), 32'd0);
    check_eq("hb_no_drive", 32'(n_oe - o0), 32'd0);

    e0 = n_err; o0 = n_oe; p0 = n_poll;
    send_word(32'h1234_5678, 32, ls);
    repeat (10) @(negedge clk);
    check_eq("err_pulses", 32'(n_err - e0), 32'd1);
    check_eq("err_no_drive", 32'(n_oe - o0), 32'd0);
    check_eq("err_no_poll", 32'(n_poll - p0), 32'd0);
    expect_poll($urandom, 32'h0101_0101, 1'b1);
    send_word(CMD_POLL, 32, ls);
    collect("poll2", 12, 1'b1);
    wait_idle("poll2");

    for (int i = 0; i < 3; i++) begin
      cmd = $urandom;
      if (cmd == CMD_POLL || cmd == CMD_HEARTBEAT) cmd = cmd ^ 32'h1;
      e0 = n_err; o0 = n_oe;
      send_word(cmd, 32, ls);
      repeat (10) @(negedge clk);
      check_eq($sformatf("rand_err%0d", i), 32'(n_err - e0), 32'd1);
      check_eq($sformatf("rand_nodrv%0d", i), 32'(n_oe - o0), 32'd0);
    end

    // Host gives up after 10 bits; the abort is timed from the start of the 10th cell.
    a0 = n_abort; e0 = n_err; p0 = n_poll; h0 = n_hb;
    send_word($urandom, 10, ls);
    n = 0;
    while (n_abort == a0 && n < int'(RX_TIMEOUT + 4 * BITLEN)) begin
      @(negedge clk);
      n++;
    end
    lat = abort_cyc - ls;
    check_eq("abort_pulses", 32'(n_abort - a0), 32'd1);
    check_eq("abort_lat_in_window",
             32'(lat >= longint'(BITLEN * 5 / 6 + RX_TIMEOUT) &&
                 lat <= longint'(BITLEN * 5 / 6 + RX_TIMEOUT + 8)), 32'd1);
    check_eq("abort_no_decode", 32'((n_err - e0) + (n_poll - p0) + (n_hb - h0)), 32'd0);
    repeat (5) @(negedge clk);
    send_word(CMD_HEARTBEAT, 32, ls);
    repeat (10) @(negedge clk);
    check_eq("abort_then_hb", 32'(n_hb - h0), 32'd1);

    // Reset in the middle of word 5 of a response.
    src_base = $urandom;
    send_word(CMD_POLL, 32, ls);
    n = 0;
    while (!(rd_idx == 4'd5 && pad_oe) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_word5", 32'(rd_idx), 32'd5);
    repeat (3 * BITLEN) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midtx_rst_oe", 32'(pad_oe), 32'd0);
    check_eq("midtx_rst_out", 32'(pad_out), 32'd1);
    check_eq("midtx_rst_idx", 32'(rd_idx), 32'd0);
    check_eq("midtx_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    expect_poll($urandom, 32'h0011_2233, 1'b1);
    send_word(CMD_POLL, 32, ls);
    collect("poll_after_rst", 12, 1'b1);
    wait_idle("poll_after_rst");

    // Source changes once word 0 has been received.
    base_a = $urandom;
    base_b = base_a ^ 32'h5A5A_0F0F;
    src_base = base_a;
    src_step = 32'h0000_0107;
    src_mask = 1'b1;
    exp_q.push_back(model_word(base_a, src_step, 1'b1, 0));
    send_word(CMD_POLL, 32, ls);
    collect("coh_w0", 1, 1'b1);
    src_base = base_b;
    for (int unsigned i = 1; i < RESP_WORDS; i++) begin
`ifdef IO_PAD_RESPONDER_SNAPSHOT_EN
      exp_q.push_back(model_word(base_a, src_step, 1'b1, i));
`else
      exp_q.push_back(model_word(base_b, src_step, 1'b1, i));
`endif
    end
    collect("coh_rest", 11, 1'b0);
    wait_idle("coh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
